// File: rtl/uart_rx_framer.sv
// UART receiver feeding a byte+last FIFO: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Each byte is staged until the next byte arrives (last=0) or IDLE_BITS idle bit-times pass (last=1).
module uart_rx_framer #(
  parameter int BAUD_DIV  = 868,
  parameter int IDLE_BITS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       fifo_full,
  output logic       fifo_wr_en,
  output logic [7:0] fifo_din,
  output logic       fifo_din_last,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int TMR_W = $clog2(IDLE_BITS * BAUD_DIV + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_TERM = TMR_W'(IDLE_BITS * BAUD_DIV);
  localparam logic [TMR_W-1:0] TMR_PRE  = TMR_W'(IDLE_BITS * BAUD_DIV - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY     = 3'd5;
  localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
`else
  localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif

  logic             rx_meta_q, rx_s_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       stage_byte_q, stage_byte_d;
  logic             stage_valid_q, stage_valid_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             wr_en_q, wr_en_d;
  logic [7:0]       din_q, din_d;
  logic             last_q, last_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic             byte_ok, frame_bad, timeout, push, push_last;
`ifdef UART_RX_PARITY_EN
  logic             par_err_q, par_err_d;
  logic             parity_err_q, par_bad;
`endif

  // Receive FSM: counter restarts on every sample so each bit is sampled mid-cell.
  always_comb begin
    // NOTE: every next-state signal takes a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_ok   = 1'b0;
    frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
    par_bad   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = ST_AFTER_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          par_err_d = ^{shift_q, rx_s_q};
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            frame_bad = 1'b1;
            state_d   = ST_BREAK;
          end
`ifdef UART_RX_PARITY_EN
          else if (par_err_q) begin
            par_bad = 1'b1;
            state_d = ST_IDLE;
          end
`endif
          else begin
            byte_ok = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Staging, idle timer and the single FIFO push port.
  always_comb begin
    stage_byte_d  = stage_byte_q;
    stage_valid_d = stage_valid_q;
    push          = 1'b0;
    push_last     = 1'b0;

    if (state_q != ST_IDLE)       timer_d = '0;
    else if (timer_q != TMR_TERM) timer_d = timer_q + 1'b1;
    else                          timer_d = timer_q;
    timeout = (state_q == ST_IDLE) && (timer_q == TMR_PRE);

    if (byte_ok) begin
      push          = stage_valid_q;
      stage_byte_d  = shift_q;
      stage_valid_d = 1'b1;
    end else if (timeout && stage_valid_q) begin
      push          = 1'b1;
      push_last     = 1'b1;
      stage_valid_d = 1'b0;
    end

    wr_en_d   = push && !fifo_full;
    overrun_d = push && fifo_full;
    din_d     = din_q;
    last_d    = last_q;
    if (push && !fifo_full) begin
      din_d  = stage_byte_q;
      last_d = push_last;
    end
    frame_err_d = frame_bad;
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      stage_byte_q  <= '0;
      stage_valid_q <= 1'b0;
      timer_q       <= '0;
      wr_en_q       <= 1'b0;
      din_q         <= '0;
      last_q        <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q     <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      // NOTE: registers update with non-blocking assignments so every flop sees pre-edge values.
      rx_meta_q     <= rx;
      rx_s_q        <= rx_meta_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      stage_byte_q  <= stage_byte_d;
      stage_valid_q <= stage_valid_d;
      timer_q       <= timer_d;
      wr_en_q       <= wr_en_d;
      din_q         <= din_d;
      last_q        <= last_d;
      frame_err_q   <= frame_err_d;
      overrun_q     <= overrun_d;
      busy_q        <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_err_q     <= par_err_d;
      parity_err_q  <= par_bad;
`endif
    end
  end

  assign fifo_wr_en    = wr_en_q;
  assign fifo_din      = din_q;
  assign fifo_din_last = last_q;
  assign frame_err     = frame_err_q;
  assign overrun       = overrun_q;
  assign busy          = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err    = parity_err_q;
`else
  assign parity_err    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer: an event-level model predicts the cycle of every
// write/error/overrun pulse; directed checks pin latency, byte order and busy behaviour.
module tb_uart_rx_framer;

  localparam int BAUD_DIV  = 16;
  localparam int IDLE_BITS = 4;
  localparam int TO_CYC    = IDLE_BITS * BAUD_DIV;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_EN   = 1;
  localparam int STOP_OFS = 170;  // 2 sync + 8 half-bit + 10 bits of 16
  localparam int LAST_OFS = 234;  // STOP_OFS + 64
`else
  localparam int PAR_EN   = 0;
  localparam int STOP_OFS = 154;  // 2 sync + 8 half-bit + 9 bits of 16
  localparam int LAST_OFS = 218;  // STOP_OFS + 64
`endif

  logic       clk, rst, rx, fifo_full;
  logic       fifo_wr_en, fifo_din_last, frame_err, parity_err, overrun, busy;
  logic [7:0] fifo_din;

  uart_rx_framer #(.BAUD_DIV(BAUD_DIV), .IDLE_BITS(IDLE_BITS)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .fifo_full     (fifo_full),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_din      (fifo_din),
    .fifo_din_last (fifo_din_last),
    .frame_err     (frame_err),
    .parity_err    (parity_err),
    .overrun       (overrun),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: expected pulses keyed by the cycle in which they are visible.
  logic [8:0] exp_wr [int];
  bit         exp_fe [int];
  bit         exp_pe [int];
  bit         exp_ov [int];
  logic       m_staged;
  logic [7:0] m_byte;
  int         m_pending;

  task automatic post_push(input int t, input logic [7:0] d, input logic l);
    if (fifo_full) exp_ov[t] = 1'b1;
    else           exp_wr[t] = {d, l};
  endtask

  // A start edge captured at edge n leaves IDLE at n+2; a timeout due by then still happens.
  task automatic m_frame_start(input int n);
    if (m_pending >= 0) begin
      if (m_pending > n + 2) begin
        exp_wr.delete(m_pending);
        exp_ov.delete(m_pending);
      end else begin
        m_staged = 1'b0;
      end
      m_pending = -1;
    end
  endtask

  task automatic m_restart_idle(input int e);
    if (m_staged) begin
      post_push(e + TO_CYC, m_byte, 1'b1);
      m_pending = e + TO_CYC;
    end
  endtask

  task automatic m_byte_ok(input int s, input logic [7:0] b);
    if (m_staged) post_push(s, m_byte, 1'b0);
    m_byte   = b;
    m_staged = 1'b1;
    post_push(s + TO_CYC, b, 1'b1);
    m_pending = s + TO_CYC;
  endtask

  task automatic m_reset();
    if (m_pending >= 0) begin
      exp_wr.delete(m_pending);
      exp_ov.delete(m_pending);
    end
    m_staged  = 1'b0;
    m_pending = -1;
  endtask

  // Observed traffic
  logic [8:0] wr_log [$];
  int wr_cnt = 0, fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, last_wr_cyc = 0;

  initial begin
    logic [3:0] e, a;
    forever begin
      @(negedge clk);
      if (!rst) begin
        e[3] = exp_wr.exists(cyc) != 0;
        e[2] = exp_fe.exists(cyc) != 0;
        e[1] = exp_pe.exists(cyc) != 0;
        e[0] = exp_ov.exists(cyc) != 0;
        a    = {fifo_wr_en, frame_err, parity_err, overrun};
        if (e != 4'b0 || a != 4'b0) check("pulses{wr,fe,pe,ov}", 32'(a), 32'(e));
        if (fifo_wr_en && e[3])
          check("wr_data_last", 32'({fifo_din, fifo_din_last}), 32'(exp_wr[cyc]));
        if (fifo_wr_en) begin
          check("wr_while_full", 32'(fifo_full), 32'd0);
          wr_cnt++;
          wr_log.push_back({fifo_din, fifo_din_last});
          last_wr_cyc = cyc;
        end
        if (frame_err)  fe_cnt++;
        if (parity_err) pe_cnt++;
        if (overrun)    ov_cnt++;
      end
    end
  end

  task automatic idle(input int k);
    rx = 1'b1;
    repeat (k) @(negedge clk);
  endtask

  // Drives one frame; leaves rx at the stop-bit level on return.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip,
                            output int n, output int s);
    @(negedge clk);
    n = cyc + 1;
    s = n + STOP_OFS;
    m_frame_start(n);
    if (!stop_bit) exp_fe[s] = 1'b1;
    else if (PAR_EN != 0 && par_flip) begin
      exp_pe[s] = 1'b1;
      m_restart_idle(s);
    end else m_byte_ok(s, b);
    rx = 1'b0;
    repeat (BAUD_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD_DIV) @(negedge clk);
      if (i == 3) check("busy_mid_frame", 32'(busy), 32'd1);
    end
    if (PAR_EN != 0) begin
      rx = (^b) ^ par_flip;
      repeat (BAUD_DIV) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BAUD_DIV) @(negedge clk);
  endtask

  initial begin
    int n, s, w0, c0, f0, o0;
    rst = 1'b1; rx = 1'b1; fifo_full = 1'b0;
    m_staged = 1'b0; m_byte = '0; m_pending = -1;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({fifo_wr_en, fifo_din, fifo_din_last, frame_err, parity_err, overrun, busy}), 32'd0);
    rst = 1'b0;
    idle(100);

    // Single byte, tagged last after the idle timeout
    c0 = wr_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, n, s);
    idle(100);
    check("single_count", 32'(wr_cnt - c0), 32'd1);
    check("single_data_last", 32'(wr_log[wr_log.size() - 1]), 32'h14B);
    check("single_latency", 32'(last_wr_cyc - n), 32'(LAST_OFS));

    // Back-to-back bytes
    w0 = wr_log.size();
    send_frame(8'h11, 1'b1, 1'b0, n, s);
    send_frame(8'h22, 1'b1, 1'b0, n, s);
    send_frame(8'h33, 1'b1, 1'b0, n, s);
    idle(100);
    check("b2b_count", 32'(wr_log.size() - w0), 32'd3);
    check("b2b_first",  32'(wr_log[w0]),     32'h022);
    check("b2b_second", 32'(wr_log[w0 + 1]), 32'h044);
    check("b2b_third",  32'(wr_log[w0 + 2]), 32'h067);
    check("b2b_idle_busy", 32'(busy), 32'd0);

    // False start: 4 low cycles; also pins the 3-cycle start-detect latency
    c0 = wr_cnt; f0 = fe_cnt;
    @(negedge clk);
    rx = 1'b0;
    n = cyc + 1;
    m_frame_start(n);
    @(negedge clk);
    @(negedge clk);
    check("start_latency_n+1", 32'(busy), 32'd0);
    @(negedge clk);
    check("start_latency_n+2", 32'(busy), 32'd1);
    @(negedge clk);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    check("false_start_busy_n+9", 32'(busy), 32'd1);
    @(negedge clk);
    check("false_start_idle_n+10", 32'(busy), 32'd0);
    m_restart_idle(n + 10);
    idle(100);
    check("false_start_no_write", 32'(wr_cnt - c0), 32'd0);
    check("false_start_no_err", 32'(fe_cnt - f0), 32'd0);

    // Framing error with a held-low line; staged byte survives
    w0 = wr_log.size(); f0 = fe_cnt;
    send_frame(8'h10, 1'b1, 1'b0, n, s);
    send_frame(8'h55, 1'b0, 1'b0, n, s);
    repeat (40) @(negedge clk);
    rx = 1'b1;
    m_restart_idle(cyc + 3);
    idle(100);
    check("frame_err_count", 32'(fe_cnt - f0), 32'd1);
    check("frame_err_writes", 32'(wr_log.size() - w0), 32'd1);
    check("frame_err_staged", 32'(wr_log[w0]), 32'h021);

    // Overrun: both pushes dropped
    fifo_full = 1'b1;
    c0 = wr_cnt; o0 = ov_cnt;
    send_frame(8'h01, 1'b1, 1'b0, n, s);
    send_frame(8'h02, 1'b1, 1'b0, n, s);
    idle(100);
    check("overrun_count", 32'(ov_cnt - o0), 32'd2);
    check("overrun_no_write", 32'(wr_cnt - c0), 32'd0);
    fifo_full = 1'b0;

    // Reset mid-frame discards the staged byte
    c0 = wr_cnt;
    send_frame(8'h77, 1'b1, 1'b0, n, s);
    @(negedge clk);
    rx = 1'b0;
    m_frame_start(cyc + 1);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    m_reset();
    @(negedge clk);
    check("reset_midframe_busy", 32'(busy), 32'd0);
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(200);
    check("reset_midframe_discard", 32'(wr_cnt - c0), 32'd0);

`ifdef UART_RX_PARITY_EN
    begin
      int p0;
      p0 = pe_cnt; w0 = wr_log.size();
      send_frame(8'h03, 1'b1, 1'b1, n, s);
      idle(100);
      check("parity_err_count", 32'(pe_cnt - p0), 32'd1);
      check("parity_err_no_write", 32'(wr_log.size() - w0), 32'd0);
      send_frame(8'h03, 1'b1, 1'b0, n, s);
      idle(100);
      check("parity_ok_write", 32'(wr_log.size() - w0), 32'd1);
      check("parity_ok_data", 32'(wr_log[w0]), 32'h007);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
